// File: rtl/demux_pkg.sv
// Shared types and sizing for the 1:WIDTH bit-collecting demultiplexor.
package demux_pkg;
  localparam int WIDTH = 8;
  localparam int SEL_W = $clog2(WIDTH);

  typedef enum logic {COLLECT, HOLD} demux_state_t;
  typedef logic [WIDTH-1:0] lane_vec_t;
endpackage

// File: rtl/decoder3to8.sv
// Select-to-one-hot decoder gated by an enable; one compare per lane.
module decoder3to8 #(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [WIDTH-1:0] onehot
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign onehot[i] = en && (sel == SEL_W'(i));
  end
endmodule

// File: rtl/demultiplexor3_collect.sv
// Registered 1:WIDTH demux that rebuilds a parallel word from a serial bit stream
// and hands it off with a valid/ready handshake.
module demultiplexor3_collect
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             auto_sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);
  demux_state_t     state, state_next;
  logic [WIDTH-1:0] mask;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] dest;
  logic [WIDTH-1:0] we;
  logic             accept;
  logic             handoff;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;
  assign dest      = auto_sel ? ptr : sel;

  decoder3to8 #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_dec (
    .sel    (dest),
    .en     (accept),
    .onehot (we)
  );

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (&(mask | we)) state_next = HOLD;
      HOLD:    if (handoff)      state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      out   <= '0;
      mask  <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      if (handoff) begin
        // out is left as-is; lanes get overwritten by the next word
        mask <= '0;
        ptr  <= '0;
      end else begin
        out  <= (out & ~we) | (we & {WIDTH{in}});
        mask <= mask | we;
        if (accept && auto_sel) ptr <= ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_demultiplexor3_collect.sv
// Directed and randomized checks of demultiplexor3_collect against a lane-array model.
module tb_demultiplexor3_collect;
  logic       clk = 0;
  logic       rst = 1;
  logic       in = 0, in_valid = 0, auto_sel = 0, out_ready = 0;
  logic [2:0] sel = 0;
  logic       in_ready, out_valid;
  logic [7:0] out;

  int pass_cnt = 0, total_cnt = 0;

  // reference model: lanes, written flags, pointer, holding flag
  bit   m_lane [8];
  bit   m_wr   [8];
  int   m_ptr;
  bit   m_hold;

  demultiplexor3_collect dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .auto_sel(auto_sel), .out(out), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_word();
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = m_lane[i];
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_lane[i] = 0; m_wr[i] = 0; end
    m_ptr = 0; m_hold = 0;
  endtask

  // Advance model by one clock edge given the inputs presented before it.
  task automatic model_edge(input bit v, input bit b, input int s, input bit a, input bit r);
    int  d;
    bit  all;
    if (m_hold) begin
      if (r) begin
        m_hold = 0; m_ptr = 0;
        for (int i = 0; i < 8; i++) m_wr[i] = 0;
      end
    end else if (v) begin
      d = a ? m_ptr : s;
      m_lane[d] = b; m_wr[d] = 1;
      if (a) m_ptr = (m_ptr + 1) % 8;
      all = 1;
      for (int i = 0; i < 8; i++) if (!m_wr[i]) all = 0;
      if (all) m_hold = 1;
    end
  endtask

  // One cycle with given inputs; inputs applied 1 time unit after the edge.
  task automatic cycle(input bit v, input bit b, input int s, input bit a, input bit r);
    in_valid = v; in = b; sel = 3'(s); auto_sel = a; out_ready = r;
    @(posedge clk); #1;
    model_edge(v, b, s, a, r);
    in_valid = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; #3; rst = 0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (out !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_init out=%h ov=%b ir=%b want 00/0/1", out, out_valid, in_ready);
    else pass_cnt++;
    cycle(1, 1, 0, 0, 0); cycle(1, 1, 1, 0, 0); cycle(1, 1, 2, 0, 0);
    total_cnt++;
    if (out !== 8'h07) $display("FAIL reset_partial out=%h want 07", out);
    else pass_cnt++;
    #2 rst = 1; #1;
    total_cnt++;
    if (out !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_midword out=%h ov=%b ir=%b want 00/0/1", out, out_valid, in_ready);
    else pass_cnt++;
    rst = 0; model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_walking(input bit first, input logic [7:0] want, input string name);
    cycle(1, first, 0, 0, 0);
    for (int s = 1; s < 8; s++) begin
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL %s_early_valid lane=%0d ov=%b want 0", name, s, out_valid);
      else pass_cnt++;
      cycle(1, !first, s, 0, 0);
    end
    total_cnt++;
    if (out !== want || out !== m_word() || out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL %s out=%b ov=%b ir=%b want %b/1/0", name, out, out_valid, in_ready, want);
    else pass_cnt++;
    cycle(0, 0, 0, 0, 1);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_handoff ov=%b ir=%b want 0/1", name, out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_auto();
    bit bits [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) cycle(1, bits[i], 7 - i, 1, 0);
    total_cnt++;
    if (out !== 8'b01001101 || out !== m_word() || out_valid !== 1'b1)
      $display("FAIL auto_word out=%b ov=%b want 01001101/1", out, out_valid);
    else pass_cnt++;
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 5, 1, 0);  // pointer restarted: lane 0 gets the bit, not lane 5
    total_cnt++;
    if (out !== 8'b01001100 || out !== m_word())
      $display("FAIL auto_restart out=%b want 01001100", out);
    else pass_cnt++;
    for (int i = 1; i < 8; i++) cycle(1, 1, 0, 1, 0);
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    for (int i = 0; i < 8; i++) cycle(1, i[0], i, 0, 0);
    held = out;
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, k, 0, 0);
      total_cnt++;
      if (out !== held || out !== m_word() || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL backpressure_%0d out=%h ov=%b ir=%b want %h/1/0", k, out, out_valid, in_ready, held);
      else pass_cnt++;
    end
    cycle(1, 0, 0, 0, 1);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== held)
      $display("FAIL backpressure_release out=%h ov=%b ir=%b want %h/0/1", out, out_valid, in_ready, held);
    else pass_cnt++;
  endtask

  task automatic test_duplicate();
    cycle(1, 1, 3, 0, 0);
    cycle(1, 0, 3, 0, 0);
    for (int s = 0; s < 8; s++) begin
      if (s == 3) continue;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL dup_early_valid lane=%0d ov=%b want 0", s, out_valid);
      else pass_cnt++;
      cycle(1, 1, s, 0, 0);
    end
    total_cnt++;
    if (out !== 8'b11110111 || out_valid !== 1'b1)
      $display("FAIL dup_word out=%b ov=%b want 11110111/1", out, out_valid);
    else pass_cnt++;
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(3) != 0, $urandom_range(1), $urandom_range(7),
            $urandom_range(1), $urandom_range(2) == 0);
      total_cnt++;
      if (out !== m_word() || out_valid !== m_hold || in_ready !== !m_hold) begin
        if (errs < 10)
          $display("FAIL random_%0d out=%h ov=%b ir=%b want %h/%b/%b",
                   n, out, out_valid, in_ready, m_word(), m_hold, !m_hold);
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_walking(1, 8'b00000001, "walk_one");
    test_walking(0, 8'b11111110, "walk_zero");
    test_auto();
    test_backpressure();
    test_duplicate();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
